lcd_msg_writer: RTL and testbench
=================================

LCD_MSG_WRITER -- requirements
Module: lcd_msg_writer

Interface
REQ-001 The block SHALL have parameter LINE_LEN, default 16, giving characters per display line; the legal range is 1..32.
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 8, giving the cycles allowed for lcd_busy to rise after a request.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 wr_en  input  1  character buffer write strobe.
REQ-006 wr_addr  input  6  buffer index, where 0..LINE_LEN-1 is line 0 and 32..32+LINE_LEN-1 is line 1.
REQ-007 wr_data  input  8  character code to store.
REQ-008 refresh  input  1  single-cycle request to copy the whole buffer to the LCD.
REQ-009 lcd_busy  input  1  busy flag from the downstream LCD controller.
REQ-010 lcd_enable  output  1  transaction request to the LCD controller.
REQ-011 lcd_bus  output  10  transaction word {rs, rw, data[7:0]}.
REQ-012 active  output  1  high while a refresh sequence is in progress.
REQ-013 done  output  1  one-cycle pulse when a refresh sequence completes.
REQ-014 err  output  1  sticky flag for an acknowledge timeout.

Function
REQ-015 The character buffer SHALL be 2 x LINE_LEN bytes and SHALL be written on the clk edge where wr_en=1; writes to unmapped indices SHALL be ignored.
REQ-016 A buffer write SHALL be accepted in every state, including during a refresh; each character value is taken at the moment it is issued.
REQ-017 The FSM states SHALL be IDLE, ISSUE, WAIT_ACK and WAIT_DONE; a step counter SHALL range over 0..2*LINE_LEN+1.
REQ-018 The refresh sequence SHALL be, in step order:
  - step 0: {0,0,0x80};
  - steps 1..LINE_LEN: {1,0,line0[i]};
  - step LINE_LEN+1: {0,0,0xC0};
  - the remaining steps: {1,0,line1[i]}.
REQ-019 IDLE: if refresh=1, the block SHALL clear the step counter, set active=1 and go to ISSUE; otherwise it stays in IDLE.
REQ-020 ISSUE: while lcd_busy=1 the block SHALL hold with lcd_enable=0.
REQ-021 ISSUE: when lcd_busy=0 the block SHALL register lcd_enable=1 with the lcd_bus word for the current step, for exactly one cycle, then go to WAIT_ACK.
REQ-022 WAIT_ACK: lcd_enable SHALL be 0 and lcd_bus SHALL hold its value; when lcd_busy=1 the block SHALL go to WAIT_DONE.
REQ-023 WAIT_ACK: after ACK_TIMEOUT cycles without lcd_busy=1, the block SHALL set err=1, drop active, and return to IDLE without pulsing done.
REQ-024 WAIT_DONE: when lcd_busy=0 the block SHALL advance the step counter.
REQ-025 WAIT_DONE: if the completed step was the last one, the block SHALL pulse done=1 for one cycle, set active=0 and go to IDLE; otherwise it SHALL go to ISSUE.
REQ-026 A refresh pulse while active=1 SHALL set a pending flag.
REQ-027 When the current sequence ends and the pending flag is set, the block SHALL clear the flag and restart from step 0 in the same cycle done pulses, so active stays 1; additional pulses SHALL merge into the one pending flag.
REQ-028 A refresh pulse in the same cycle as completion SHALL be treated as pending.
REQ-029 lcd_enable SHALL never be high for two consecutive cycles, and SHALL never be asserted while the sampled lcd_busy=1.
REQ-030 The rw bit of lcd_bus SHALL always be 0.
REQ-031 A refresh pulse SHALL clear err.

Reset
REQ-032 rst=1 SHALL force:
  - state IDLE, step 0, pending flag 0;
  - lcd_enable=0, lcd_bus=0, active=0, done=0, err=0;
  - every buffer byte to 0x20 (space).
REQ-033 rst asserted mid-sequence SHALL abort the sequence at the next edge with no further lcd_enable pulse; rst SHALL take priority over every other input.

Verification
REQ-034 Reset, then refresh with an ideal LCD model (busy 1 cycle after enable, held 3 cycles) -> 34 enable pulses: 0x080, sixteen 0x220, 0x0C0, sixteen 0x220; done pulses once.
REQ-035 Write 'H'(0x48) to index 0 and 'i'(0x69) to index 33, then refresh -> the 2nd word is 0x248 and the 20th word is 0x269.
REQ-036 Hold lcd_busy=1 for 2500 cycles, then release (power-up) -> no lcd_enable until release; the first word is 0x080.
REQ-037 LCD model never raises busy -> err=1 after 8 cycles in WAIT_ACK, active=0, no done; a following refresh clears err.
REQ-038 Two refresh pulses during an active sequence -> exactly two full sequences (68 enables), active stays high between them, and two done pulses.
REQ-039 rst at step 10 -> lcd_enable=0 and active=0 the next cycle; the buffer reads back 0x20.

Source files
------------

// File: rtl/lcd_msg_writer.sv
// Two-line character buffer that streams its contents to an LCD controller on request,
// using a request/busy handshake with an acknowledge timeout.
module lcd_msg_writer #(
  parameter int LINE_LEN    = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [5:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       refresh,
  input  logic       lcd_busy,
  output logic       lcd_enable,
  output logic [9:0] lcd_bus,
  output logic       active,
  output logic       done,
  output logic       err
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [6:0] LEN       = 7'(LINE_LEN);
  localparam logic [6:0] LINE1_HDR = 7'(LINE_LEN + 1);
  localparam logic [6:0] LAST_STEP = 7'(2 * LINE_LEN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state;
  logic [6:0]    step;
  logic [TW-1:0] timer;
  logic          pending;

  // Slots at or above LINE_LEN are never written and stay constant.
  logic [7:0] line0 [32];
  logic [7:0] line1 [32];

  logic       wr_line0;
  logic       wr_line1;
  logic [4:0] idx0;
  logic [4:0] idx1;
  logic [9:0] step_word;

  always_comb begin
    wr_line0 = wr_en && !wr_addr[5] && ({2'b00, wr_addr[4:0]} < LEN);
    wr_line1 = wr_en &&  wr_addr[5] && ({2'b00, wr_addr[4:0]} < LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        line0[i] <= 8'h20;
        line1[i] <= 8'h20;
      end
    end else if (wr_line0) begin
      line0[wr_addr[4:0]] <= wr_data;
    end else if (wr_line1) begin
      line1[wr_addr[4:0]] <= wr_data;
    end
  end

  // Word for the current step: line-0 home, line-0 chars, line-1 home, line-1 chars.
  always_comb begin
    idx0      = 5'(step - 7'd1);
    idx1      = 5'(step - LINE1_HDR - 7'd1);
    step_word = {2'b10, 8'h00};
    if (step == 7'd0) begin
      step_word = {2'b00, 8'h80};
    end else if (step <= LEN) begin
      step_word = {2'b10, line0[idx0]};
    end else if (step == LINE1_HDR) begin
      step_word = {2'b00, 8'hC0};
    end else begin
      step_word = {2'b10, line1[idx1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      step       <= 7'd0;
      timer      <= '0;
      pending    <= 1'b0;
      lcd_enable <= 1'b0;
      lcd_bus    <= 10'd0;
      active     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      lcd_enable <= 1'b0;
      done       <= 1'b0;
      if (refresh) begin
        err <= 1'b0;
      end
      if (refresh && active) begin
        pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (refresh) begin
            step   <= 7'd0;
            active <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!lcd_busy) begin
            lcd_enable <= 1'b1;
            lcd_bus    <= step_word;
            timer      <= '0;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (lcd_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            err     <= 1'b1;
            active  <= 1'b0;
            pending <= 1'b0;
            state   <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!lcd_busy) begin
            if (step == LAST_STEP) begin
              // A queued or coincident refresh restarts without dropping active.
              done <= 1'b1;
              step <= 7'd0;
              if (pending || refresh) begin
                pending <= 1'b0;
                state   <= ISSUE;
              end else begin
                active <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              step  <= step + 7'd1;
              state <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_msg_writer.sv
// Bench for lcd_msg_writer: a buffer/queue model predicts every LCD word, and a monitor
// checks each enable pulse against it alongside directed scenario checks.
module tb_lcd_msg_writer;

  localparam int L = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic       lcd_busy;
  logic       lcd_enable;
  logic [9:0] lcd_bus;
  logic       active;
  logic       done;
  logic       err;

  int tests = 0;
  int fails = 0;

  logic [7:0] model_mem [64];
  logic [9:0] exp_q[$];
  logic [9:0] word_log[$];
  int         enable_count = 0;
  logic       busy_sampled = 1'b0;
  logic       prev_enable = 1'b0;

  int   lcd_mode = 0;
  logic force_busy = 1'b0;
  logic arm = 1'b0;
  int   hold = 0;

  lcd_msg_writer #(.LINE_LEN(L), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .refresh(refresh), .lcd_busy(lcd_busy), .lcd_enable(lcd_enable),
    .lcd_bus(lcd_bus), .active(active), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [5:0] a, input logic [7:0] d, input logic rf);
    wr_en   = we;
    wr_addr = a;
    wr_data = d;
    refresh = rf;
    if (we && int'(a[4:0]) < L) model_mem[a] = d;
    @(negedge clk);
    wr_en   = 1'b0;
    refresh = 1'b0;
  endtask

  task automatic push_sequence();
    exp_q.push_back(10'h080);
    for (int i = 0; i < L; i++) exp_q.push_back({2'b10, model_mem[i]});
    exp_q.push_back(10'h0C0);
    for (int i = 0; i < L; i++) exp_q.push_back({2'b10, model_mem[32 + i]});
  endtask

  task automatic reset_model();
    for (int i = 0; i < 64; i++) model_mem[i] = 8'h20;
  endtask

  task automatic wait_dones(input int n, input int bound, input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < bound && seen < n; k++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput({name, "_done_count"}, seen, n);
  endtask

  // LCD controller model: busy rises one cycle after an enable and holds for three cycles.
  initial begin
    lcd_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (force_busy) begin
        lcd_busy = 1'b1;
        arm = 1'b0;
        hold = 0;
      end else if (lcd_mode == 1) begin
        lcd_busy = 1'b0;
      end else begin
        if (arm) begin
          arm = 1'b0;
          lcd_busy = 1'b1;
          hold = 2;
        end else if (hold > 0) begin
          hold--;
        end else begin
          lcd_busy = 1'b0;
        end
        if (lcd_enable) arm = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      busy_sampled = lcd_busy;
    end
  end

  // Monitor: every enable pulse is checked against the predicted word stream.
  initial begin
    logic [9:0] expw;
    forever begin
      @(negedge clk);
      if (lcd_enable === 1'b1) begin
        enable_count++;
        word_log.push_back(lcd_bus);
        checkOutput("enable_consecutive", prev_enable, 0);
        checkOutput("enable_while_busy", busy_sampled, 0);
        checkOutput("rw_bit", lcd_bus[8], 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_enable: got 0x%0h, expected no enable", lcd_bus);
        end else begin
          expw = exp_q.pop_front();
          checkOutput("enable_word", lcd_bus, expw);
        end
      end
      prev_enable = (lcd_enable === 1'b1);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int seen;
    int local_done;
    logic dropped;
    logic saw_done;

    rst = 1'b1; wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'd0; refresh = 1'b0;
    reset_model();
    repeat (3) @(negedge clk);
    checkOutput("reset_enable", lcd_enable, 0);
    checkOutput("reset_bus", lcd_bus, 0);
    checkOutput("reset_active", active, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Default buffer contents
    word_log.delete();
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    checkOutput("t1_active", active, 1);
    wait_dones(1, 1000, "t1");
    checkOutput("t1_active_end", active, 0);
    checkOutput("t1_words", word_log.size(), 34);
    checkOutput("t1_word0", word_log[0], 10'h080);
    checkOutput("t1_word1", word_log[1], 10'h220);
    checkOutput("t1_word17", word_log[17], 10'h0C0);
    checkOutput("t1_queue_empty", exp_q.size(), 0);

    // Writes including line boundaries and unmapped indices
    applyStimulus(1'b1, 6'd0,  8'h48, 1'b0);
    applyStimulus(1'b1, 6'd33, 8'h69, 1'b0);
    applyStimulus(1'b1, 6'd15, 8'h5A, 1'b0);
    applyStimulus(1'b1, 6'd47, 8'h7A, 1'b0);
    applyStimulus(1'b1, 6'd20, 8'h41, 1'b0);
    applyStimulus(1'b1, 6'd63, 8'h42, 1'b0);
    word_log.delete();
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    wait_dones(1, 1000, "t2");
    checkOutput("t2_word1", word_log[1], 10'h248);
    checkOutput("t2_word19", word_log[19], 10'h269);
    checkOutput("t2_word16", word_log[16], 10'h25A);
    checkOutput("t2_word33", word_log[33], 10'h27A);
    checkOutput("t2_word2", word_log[2], 10'h220);

    // Long power-up busy
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    word_log.delete();
    base = enable_count;
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    repeat (2500) @(negedge clk);
    checkOutput("t3_no_enable", enable_count - base, 0);
    checkOutput("t3_active", active, 1);
    force_busy = 1'b0;
    wait_dones(1, 1000, "t3");
    checkOutput("t3_first_word", word_log[0], 10'h080);
    checkOutput("t3_words", word_log.size(), 34);

    // Acknowledge timeout
    lcd_mode = 1;
    repeat (6) @(negedge clk);
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (lcd_enable) seen = 1;
      else @(negedge clk);
    end
    checkOutput("t4_enable_seen", seen, 1);
    saw_done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      checkOutput("t4_err_timing", err, (k == 8) ? 1 : 0);
    end
    checkOutput("t4_active", active, 0);
    checkOutput("t4_no_done", saw_done, 0);
    checkOutput("t4_remaining", exp_q.size(), 33);
    exp_q.delete();
    repeat (5) @(negedge clk);
    checkOutput("t4_err_sticky", err, 1);
    lcd_mode = 0;
    @(negedge clk);
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    checkOutput("t4_err_cleared", err, 0);
    wait_dones(1, 1000, "t4");

    // Refresh pulses merged while active
    word_log.delete();
    base = enable_count;
    push_sequence();
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    repeat (40) @(negedge clk);
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    repeat (30) @(negedge clk);
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    local_done = 0;
    dropped = 1'b0;
    for (int k = 0; k < 3000 && local_done < 2; k++) begin
      @(negedge clk);
      if (done) local_done++;
      if (local_done < 2 && !active) dropped = 1'b1;
    end
    checkOutput("t5_done_count", local_done, 2);
    checkOutput("t5_active_held", dropped, 0);
    repeat (20) @(negedge clk);
    checkOutput("t5_enables", enable_count - base, 68);
    checkOutput("t5_queue_empty", exp_q.size(), 0);
    checkOutput("t5_active_end", active, 0);

    // Reset mid-sequence
    word_log.delete();
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    for (int k = 0; k < 500 && word_log.size() < 11; k++) @(negedge clk);
    checkOutput("t6_reached_step10", word_log.size(), 11);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_enable", lcd_enable, 0);
    checkOutput("t6_active", active, 0);
    checkOutput("t6_bus", lcd_bus, 0);
    rst = 1'b0;
    exp_q.delete();
    reset_model();
    base = enable_count;
    repeat (30) @(negedge clk);
    checkOutput("t6_no_enable", enable_count - base, 0);
    word_log.delete();
    push_sequence();
    applyStimulus(1'b0, 6'd0, 8'd0, 1'b1);
    wait_dones(1, 1000, "t6");
    checkOutput("t6_buffer_cleared0", word_log[1], 10'h220);
    checkOutput("t6_buffer_cleared1", word_log[19], 10'h220);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
